data_mem_ctrl: RTL
==================

Name: data_mem_ctrl

Overview:
- Parametrised successor to the single-cycle data memory.
- Word-organised RAM behind a valid/ready request port and a registered response port, with programmable wait-state latency and RISC-V byte/half/word load-store typing (sign/zero extension).
- Flags misaligned, out-of-range and illegal-type accesses.
- Sits between the core's load/store unit and on-chip data RAM; lets a multi-cycle or pipelined core tolerate slow memory.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; must be a power of two, at least 4.
- LATENCY, 1, wait-state cycles between request accept and response (legal 0..15).
- ADDR_W, 32, byte-address width of req_addr.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_we  in  1  1=store, 0=load
- req_addr  in  ADDR_W  byte address
- req_rw_type  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_wdata  in  32  store data (low bits used for B/H)
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  access faulted; valid with rsp_valid

Interface rule: one clock; reset is synchronous and active-high.

Behaviour:
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid, latch we/addr/type/wdata. Go to WAIT if LATENCY>0 (load wait counter with LATENCY-1), else go to RESP.
  - WAIT: req_ready=0. Decrement the counter. When the counter is 0, go to RESP.
  - RESP: rsp_valid=1 for exactly one cycle, then IDLE. req_ready=0 in RESP.
- Timing: accept on edge T. rsp_valid is high in cycle T+1+LATENCY. Back-to-back issue interval is LATENCY+2 cycles.
- Memory access (load data capture and store commit) happens on the edge that enters RESP. rsp_rdata and rsp_err are registered on that edge.
  - A load issued after a store always sees the stored data.
- Loads:
  - Byte lane selected by addr[1:0]; halfword lane by addr[1].
  - B/H sign-extend; BU/HU zero-extend; W is passed unchanged.
- Stores:
  - Byte-masked write of the addressed lanes only; other bytes are preserved.
  - Store with type BU/HU is illegal.
- Errors (rsp_err=1, no write, rsp_rdata=0):
  - H/HU with addr[0]=1.
  - W with addr[1:0]!=0.
  - addr >= DEPTH_WORDS*4.
  - rw_type 011/110/111.
  - Store with BU/HU.
- Reset:
  - rst forces IDLE, counter 0, rsp_valid=0, rsp_rdata=0, rsp_err=0. req_ready=1 from the first cycle after reset.
  - Reset during WAIT aborts the access: no write, no response.
  - RAM contents are not cleared by reset.
- req_valid while req_ready=0 is ignored. The requester must hold req_valid until accepted.

Optional Feature:
- Macro: DATA_MEM_CTRL_STATS_EN.
- Defined: adds outputs stat_loads, stat_stores, stat_errs (32 bits each).
  - Saturating counters (stick at 0xFFFFFFFF), cleared by rst.
  - Each increments on the RESP-entry edge: errors count only in stat_errs; successful loads/stores count in their own counter.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package mem_ctrl_pkg:
  - rw_type localparams (RW_B, RW_H, RW_W, RW_BU, RW_HU).
  - FSM state encoding.
  - Error-check function.
- Sub-module mem_lane_align: combinational. Generates the store byte-mask and shifted write data, and performs load lane extraction with sign/zero extension.
- RAM array, FSM and counters live in data_mem_ctrl.

Test Plan:
- LATENCY=2: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rsp_valid exactly 3 cycles after each accept; rdata=0xDEADBEEF, err=0.
- After the above: LB 0x13 -> 0xFFFFFFDE. LBU 0x13 -> 0x000000DE. LH 0x10 -> 0xFFFFBEEF. LHU 0x12 -> 0x0000DEAD.
- SB 0x11 data 0x12345677 over 0xDEADBEEF, then LW 0x10 -> 0xDEAD77EF (other bytes preserved).
- LW 0x12, SH 0x11, LW 0x400 (DEPTH_WORDS=256), type 011 -> each gives err=1, rdata=0; a follow-up LW 0x10 shows memory unchanged.
- LATENCY=3: assert rst during WAIT of SW 0x20 data 0x55 -> no rsp_valid, req_ready=1 the next cycle; LW 0x20 returns the prior contents.
- LATENCY=0, valid held high continuously -> accepts every 2nd cycle, rsp_valid on the cycle after each accept. With DATA_MEM_CTRL_STATS_EN: 3 loads, 2 stores, 1 error -> stats read 3/2/1.

Source files
------------

// File: rtl/data_mem_ctrl_pkg.sv
// Shared types for data_mem_ctrl: RISC-V load/store type codes, FSM state
// encoding and the access legality check.
package mem_ctrl_pkg;

  localparam logic [2:0] RW_B  = 3'b000;
  localparam logic [2:0] RW_H  = 3'b001;
  localparam logic [2:0] RW_W  = 3'b010;
  localparam logic [2:0] RW_BU = 3'b100;
  localparam logic [2:0] RW_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  function automatic logic access_err(input logic       we,
                                      input logic [2:0] rw_type,
                                      input logic [1:0] addr_lo,
                                      input logic       in_range);
    logic err;
    err = !in_range;
    case (rw_type)
      RW_B:    err = err;
      RW_BU:   err = err | we;
      RW_H:    err = err | addr_lo[0];
      RW_HU:   err = err | we | addr_lo[0];
      RW_W:    err = err | (addr_lo != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/data_mem_ctrl_lane_align.sv
// Byte-lane steering for data_mem_ctrl: store byte-enables and replicated write
// data, plus load lane extraction with sign/zero extension.
module mem_lane_align
  import mem_ctrl_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  rw_type_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Write data is replicated across lanes so the byte-enable alone picks the target.
  always_comb begin
    be_o    = '0;
    wdata_o = '0;
    case (rw_type_i)
      RW_B, RW_BU: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      RW_H, RW_HU: begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
      end
      default: begin
        be_o    = '1;
        wdata_o = wdata_i;
      end
    endcase
  end

  always_comb begin
    byte_sel = rword_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
    case (rw_type_i)
      RW_B:    rdata_o = {{24{byte_sel[7]}}, byte_sel};
      RW_BU:   rdata_o = {24'b0, byte_sel};
      RW_H:    rdata_o = {{16{half_sel[15]}}, half_sel};
      RW_HU:   rdata_o = {16'b0, half_sel};
      default: rdata_o = rword_i;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Word RAM behind a valid/ready request port with programmable wait states.
// Define DATA_MEM_CTRL_STATS_EN to add saturating load/store/error counters.
module data_mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 1,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_rw_type,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
`ifdef DATA_MEM_CTRL_STATS_EN
  ,
  output logic [31:0]       stat_loads,
  output logic [31:0]       stat_stores,
  output logic [31:0]       stat_errs
`endif
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        type_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic              enter_resp;

  logic [31:0]       mem [DEPTH_WORDS];

  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [2:0]        acc_type;
  logic [31:0]       acc_wdata;
  logic              acc_err;
  logic [AW-1:0]     word_idx;
  logic [3:0]        be;
  logic [31:0]       wdata_sh;
  logic [31:0]       load_data;

  // With zero wait states RESP is entered on the accept edge, before the latch holds the request.
  always_comb begin
    if (state_q == S_IDLE) begin
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_type  = req_rw_type;
      acc_wdata = req_wdata;
    end else begin
      acc_we    = we_q;
      acc_addr  = addr_q;
      acc_type  = type_q;
      acc_wdata = wdata_q;
    end
  end

  assign word_idx = acc_addr[AW+1:2];
  assign acc_err  = access_err(acc_we, acc_type, acc_addr[1:0],
                               (acc_addr >> (AW + 2)) == '0);

  mem_lane_align u_align (
    .addr_lo_i (acc_addr[1:0]),
    .rw_type_i (acc_type),
    .wdata_i   (acc_wdata),
    .rword_i   (mem[word_idx]),
    .be_o      (be),
    .wdata_o   (wdata_sh),
    .rdata_o   (load_data)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (LATENCY == 0) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_IDLE && req_valid) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        type_q  <= req_rw_type;
        wdata_q <= req_wdata;
      end
      if (enter_resp) begin
        err_q   <= acc_err;
        rdata_q <= (acc_err || acc_we) ? '0 : load_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && enter_resp && acc_we && !acc_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[word_idx][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

`ifdef DATA_MEM_CTRL_STATS_EN
  logic [31:0] loads_q, stores_q, errs_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      loads_q  <= '0;
      stores_q <= '0;
      errs_q   <= '0;
    end else if (enter_resp) begin
      if (acc_err) begin
        if (errs_q != '1) errs_q <= errs_q + 32'd1;
      end else if (acc_we) begin
        if (stores_q != '1) stores_q <= stores_q + 32'd1;
      end else begin
        if (loads_q != '1) loads_q <= loads_q + 32'd1;
      end
    end
  end

  assign stat_loads  = loads_q;
  assign stat_stores = stores_q;
  assign stat_errs   = errs_q;
`endif

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
